// File: rtl/control_sequencer.sv
// Control sequencer for the accumulator processor.
// Decodes the IR and drives the datapath strobes. All state and outputs change on
// the falling clock edge, and every output is registered. The outputs set on an edge
// belong to the state being left on that edge.
module control_sequencer #(
  parameter int              INSTR_W       = 16,
  parameter int              SRC_W         = 4,
  parameter int              DST_W         = 3,
  parameter logic [SRC_W-1:0] CONST_SEL    = SRC_W'(11),
  parameter bit              MEM_HANDSHAKE = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               zero_flag,
  input  logic               mem_ready,
  input  logic               tx_done,
  output logic               load_instruction,
  output logic [3:0]         ALU_control,
  output logic [SRC_W-1:0]   select_source,
  output logic [DST_W-1:0]   select_destination,
  output logic [1:0]         IDC_control,
  output logic [1:0]         MDR_control,
  output logic [1:0]         MAR_control,
  output logic [1:0]         PC_control,
  output logic               write_DRAM,
  output logic               start_Tx,
  output logic               halted,
  output logic [4:0]         o_dbg_state
);

  localparam logic [4:0] S_START   = 5'd0;
  localparam logic [4:0] S_FETCH1  = 5'd1;
  localparam logic [4:0] S_FETCH2  = 5'd2;
  localparam logic [4:0] S_NOP     = 5'd3;
  localparam logic [4:0] S_LOAD1   = 5'd4;
  localparam logic [4:0] S_LOAD2   = 5'd5;
  localparam logic [4:0] S_STORE1  = 5'd6;
  localparam logic [4:0] S_STORE2  = 5'd7;
  localparam logic [4:0] S_COPY1   = 5'd8;
  localparam logic [4:0] S_COPY2   = 5'd9;
  localparam logic [4:0] S_JUMP    = 5'd10;
  localparam logic [4:0] S_JPZ     = 5'd11;
  localparam logic [4:0] S_ARITH1  = 5'd12;  // ADD/SUB/MUL/DIV operand phase
  localparam logic [4:0] S_ARITH2  = 5'd13;  // ADD/SUB/MUL/DIV ALU phase
  localparam logic [4:0] S_UNARY   = 5'd14;  // CLR/INC/DEC
  localparam logic [4:0] S_LOADK   = 5'd15;
  localparam logic [4:0] S_END     = 5'd16;
  localparam logic [4:0] S_TX_WAIT = 5'd17;
  localparam logic [4:0] S_HALT    = 5'd18;

  logic [4:0]       r_state;
  logic [3:0]       r_op;
  logic [SRC_W-1:0] r_src;
  logic [DST_W-1:0] r_dst;

  logic             r_ld;
  logic [3:0]       r_alu;
  logic [SRC_W-1:0] r_sel_src;
  logic [DST_W-1:0] r_sel_dst;
  logic [1:0]       r_idc, r_mdr, r_mar, r_pc;
  logic             r_wr, r_tx, r_halted;

  logic [4:0]       w_nxt_state;
  logic             w_ld;
  logic [3:0]       w_alu;
  logic [SRC_W-1:0] w_sel_src;
  logic [DST_W-1:0] w_sel_dst;
  logic [1:0]       w_idc, w_mdr, w_mar, w_pc;
  logic             w_wr, w_tx, w_halted;

  // Raw decode fields, only consumed in FETCH2; later states use the latched copies.
  logic [3:0]       w_op;
  logic [SRC_W-1:0] w_src;
  logic [DST_W-1:0] w_dst;
  logic             w_unused_ir;

  assign w_op        = instruction[INSTR_W-1 -: 4];
  assign w_src       = instruction[INSTR_W-5 -: SRC_W];
  assign w_dst       = instruction[DST_W-1:0];
  assign w_unused_ir = ^instruction;

  // Next state and next output values for the state currently held.
  always_comb begin
    w_nxt_state = S_START;
    w_ld        = 1'b0;
    w_alu       = 4'd0;
    w_sel_src   = '0;
    w_sel_dst   = '0;
    w_idc       = 2'd0;
    w_mdr       = 2'd0;
    w_mar       = 2'd0;
    w_pc        = 2'd0;
    w_wr        = 1'b0;
    w_tx        = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_START:  w_nxt_state = S_FETCH1;
      S_FETCH1: begin
        if (enable) begin
          w_ld        = 1'b1;
          w_nxt_state = S_FETCH2;
        end else begin
          w_nxt_state = S_FETCH1;
        end
      end
      S_FETCH2: begin
        w_pc = 2'd1;
        case (w_op)
          4'd1:                    w_nxt_state = S_LOAD1;
          4'd2:                    w_nxt_state = S_STORE1;
          4'd3:                    w_nxt_state = S_COPY1;
          4'd4:                    w_nxt_state = S_JUMP;
          4'd5, 4'd6, 4'd7, 4'd8:  w_nxt_state = S_ARITH1;
          4'd9, 4'd10, 4'd11:      w_nxt_state = S_UNARY;
          4'd12:                   w_nxt_state = S_LOADK;
          4'd13:                   w_nxt_state = S_JPZ;
          4'd15:                   w_nxt_state = S_END;
          default:                 w_nxt_state = S_NOP;
        endcase
      end
      S_NOP: w_nxt_state = S_FETCH1;
      S_LOAD1: begin
        w_mar = (r_src == SRC_W'(1)) ? 2'd1 : (r_src == SRC_W'(2)) ? 2'd2 : 2'd0;
        w_nxt_state = S_LOAD2;
      end
      S_LOAD2: begin
        w_mdr       = 2'd1;
        w_nxt_state = (!MEM_HANDSHAKE || mem_ready) ? S_FETCH1 : S_LOAD2;
      end
      S_STORE1: begin
        w_mar = (r_src == SRC_W'(1)) ? 2'd1 : (r_src == SRC_W'(2)) ? 2'd3 : 2'd0;
        w_nxt_state = S_STORE2;
      end
      S_STORE2: begin
        w_wr        = 1'b1;
        w_nxt_state = (!MEM_HANDSHAKE || mem_ready) ? S_FETCH1 : S_STORE2;
      end
      S_COPY1: begin
        w_sel_src   = r_src;
        w_nxt_state = S_COPY2;
      end
      S_COPY2: begin
        // AC and MDR are not plain bus destinations: AC loads through the ALU, MDR via its mux.
        if (r_dst == DST_W'(1)) begin
          w_alu = 4'd5;
        end else if (r_dst == DST_W'(5)) begin
          w_sel_dst = DST_W'(5);
          w_mdr     = 2'd2;
        end else begin
          w_sel_dst = r_dst;
        end
        w_nxt_state = S_FETCH1;
      end
      S_JUMP: begin
        w_pc        = 2'd2;
        w_nxt_state = S_FETCH1;
      end
      S_JPZ: begin
        w_pc        = zero_flag ? 2'd2 : 2'd0;
        w_nxt_state = S_FETCH1;
      end
      S_ARITH1: begin
        // MUL/DIV always take the instruction constant as operand.
        w_sel_src   = (r_op == 4'd7 || r_op == 4'd8) ? CONST_SEL : r_src;
        w_nxt_state = S_ARITH2;
      end
      S_ARITH2: begin
        case (r_op)
          4'd5:    w_alu = 4'd1;
          4'd6:    w_alu = 4'd2;
          4'd7:    w_alu = 4'd3;
          default: w_alu = 4'd4;
        endcase
        w_nxt_state = S_FETCH1;
      end
      S_UNARY: begin
        // Source 1 is the accumulator, handled by the ALU; anything else uses the IDC.
        if (r_src == SRC_W'(1)) begin
          case (r_op)
            4'd9:    w_alu = 4'd9;
            4'd10:   w_alu = 4'd7;
            default: w_alu = 4'd8;
          endcase
        end else begin
          case (r_op)
            4'd9:    w_idc = 2'd3;
            4'd10:   w_idc = 2'd1;
            default: w_idc = 2'd2;
          endcase
        end
        w_nxt_state = S_FETCH1;
      end
      S_LOADK: begin
        w_alu       = 4'd6;
        w_nxt_state = S_FETCH1;
      end
      S_END: begin
        w_tx        = 1'b1;
        w_nxt_state = S_TX_WAIT;
      end
      S_TX_WAIT: w_nxt_state = tx_done ? S_HALT : S_TX_WAIT;
      S_HALT: begin
        w_halted    = 1'b1;
        w_nxt_state = S_HALT;
      end
      default: w_nxt_state = S_START;
    endcase
  end

  // State, latched decode fields and registered outputs, all on the falling edge.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_START;
      r_op      <= 4'd0;
      r_src     <= '0;
      r_dst     <= '0;
      r_ld      <= 1'b0;
      r_alu     <= 4'd0;
      r_sel_src <= '0;
      r_sel_dst <= '0;
      r_idc     <= 2'd0;
      r_mdr     <= 2'd0;
      r_mar     <= 2'd0;
      r_pc      <= 2'd0;
      r_wr      <= 1'b0;
      r_tx      <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      if (r_state == S_FETCH2) begin
        r_op  <= w_op;
        r_src <= w_src;
        r_dst <= w_dst;
      end
      r_ld      <= w_ld;
      r_alu     <= w_alu;
      r_sel_src <= w_sel_src;
      r_sel_dst <= w_sel_dst;
      r_idc     <= w_idc;
      r_mdr     <= w_mdr;
      r_mar     <= w_mar;
      r_pc      <= w_pc;
      r_wr      <= w_wr;
      r_tx      <= w_tx;
      r_halted  <= w_halted;
    end
  end

  assign load_instruction   = r_ld;
  assign ALU_control        = r_alu;
  assign select_source      = r_sel_src;
  assign select_destination = r_sel_dst;
  assign IDC_control        = r_idc;
  assign MDR_control        = r_mdr;
  assign MAR_control        = r_mar;
  assign PC_control         = r_pc;
  assign write_DRAM         = r_wr;
  assign start_Tx           = r_tx;
  assign halted             = r_halted;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions, expected per-cycle output
// vectors built from the instruction semantics, one compare process.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset, enable, zero_flag, mem_ready, tx_done;
  logic [15:0] instruction;
  logic        load_instruction, write_DRAM, start_Tx, halted;
  logic [3:0]  ALU_control, select_source;
  logic [2:0]  select_destination;
  logic [1:0]  IDC_control, MDR_control, MAR_control, PC_control;
  logic [4:0]  o_dbg_state;

  typedef struct packed {
    logic       ld;
    logic [3:0] alu;
    logic [3:0] src;
    logic [2:0] dst;
    logic [1:0] idc;
    logic [1:0] mdr;
    logic [1:0] mar;
    logic [1:0] pc;
    logic       wr;
    logic       tx;
    logic       hlt;
  } vec_t;

  logic [22:0] exp_q[$];
  logic [22:0] act_v, exp_v;
  int checks = 0;
  int failures = 0;
  int tx_pulses = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .enable(enable), .instruction(instruction),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .tx_done(tx_done),
    .load_instruction(load_instruction), .ALU_control(ALU_control),
    .select_source(select_source), .select_destination(select_destination),
    .IDC_control(IDC_control), .MDR_control(MDR_control), .MAR_control(MAR_control),
    .PC_control(PC_control), .write_DRAM(write_DRAM), .start_Tx(start_Tx),
    .halted(halted), .o_dbg_state(o_dbg_state)
  );

  // Clock: DUT acts on the falling edge, bench samples on the rising edge.
  always #5 clock = ~clock;

  assign act_v = {load_instruction, ALU_control, select_source, select_destination,
                  IDC_control, MDR_control, MAR_control, PC_control,
                  write_DRAM, start_Tx, halted};

  // Scoreboard: one expected vector per falling edge, checked on the next rising edge.
  always @(posedge clock) begin
    if (start_Tx) tx_pulses++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, act_v, exp_v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Inputs that the upcoming state must ignore get random values.
  task automatic noise();
    zero_flag = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1));
    tx_done   = 1'($urandom_range(0, 1));
  endtask

  // Called just after a rising edge with inputs set for the coming falling edge.
  task automatic run_cycle(input vec_t v);
    exp_q.push_back(v);
    @(posedge clock);
    #1;
  endtask

  // Fetch + execute one instruction. waits = cycles mem_ready (or tx_done) stays low.
  task automatic do_instr(input logic [15:0] ir, input int waits, input logic zf,
                          input logic swap_ir);
    logic [3:0] op;
    logic [3:0] src;
    logic [2:0] dst;
    vec_t v;
    op  = ir[15:12];
    src = ir[11:8];
    dst = ir[2:0];
    noise(); enable = 1'b1; instruction = ir;
    v = '0; v.ld = 1'b1; run_cycle(v);
    noise(); enable = 1'($urandom_range(0, 1));
    v = '0; v.pc = 2'd1; run_cycle(v);
    // The IR is no longer meant to matter once the fields are latched.
    instruction = swap_ir ? 16'hF000 : 16'($urandom);
    noise();
    v = '0;
    case (op)
      4'd1, 4'd2: begin
        if (op == 4'd1) v.mar = (src == 4'd1) ? 2'd1 : (src == 4'd2) ? 2'd2 : 2'd0;
        else            v.mar = (src == 4'd1) ? 2'd1 : (src == 4'd2) ? 2'd3 : 2'd0;
        run_cycle(v);
        for (int i = 0; i <= waits; i++) begin
          noise();
          mem_ready = (i == waits);
          v = '0;
          if (op == 4'd1) v.mdr = 2'd1; else v.wr = 1'b1;
          run_cycle(v);
        end
      end
      4'd3: begin
        v.src = src; run_cycle(v);
        noise(); v = '0;
        if (dst == 3'd1) v.alu = 4'd5;
        else if (dst == 3'd5) begin v.dst = 3'd5; v.mdr = 2'd2; end
        else v.dst = dst;
        run_cycle(v);
      end
      4'd4:  begin v.pc = 2'd2; run_cycle(v); end
      4'd13: begin zero_flag = zf; v.pc = zf ? 2'd2 : 2'd0; run_cycle(v); end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        v.src = (op >= 4'd7) ? 4'hB : src; run_cycle(v);
        noise(); v = '0; v.alu = op - 4'd4; run_cycle(v);
      end
      4'd9, 4'd10, 4'd11: begin
        if (src == 4'd1) v.alu = (op == 4'd9) ? 4'd9 : (op == 4'd10) ? 4'd7 : 4'd8;
        else             v.idc = (op == 4'd9) ? 2'd3 : (op == 4'd10) ? 2'd1 : 2'd2;
        run_cycle(v);
      end
      4'd12: begin v.alu = 4'd6; run_cycle(v); end
      4'd15: begin
        v.tx = 1'b1; run_cycle(v);
        for (int i = 0; i <= waits; i++) begin
          noise(); tx_done = (i == waits); run_cycle('0);
        end
        for (int i = 0; i < 4; i++) begin
          noise(); enable = 1'b1; v = '0; v.hlt = 1'b1; run_cycle(v);
        end
      end
      default: run_cycle(v);
    endcase
  endtask

  logic [15:0] tbl_ir[20] = '{16'h0000, 16'hE000, 16'h1100, 16'h1300, 16'h2100,
                              16'h2200, 16'h2500, 16'h3201, 16'h3403, 16'h4000,
                              16'h6300, 16'h7000, 16'h8000, 16'h9100, 16'h9200,
                              16'hA100, 16'hA300, 16'hB100, 16'hB200, 16'hC000};
  int tbl_wait[20] = '{0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    vec_t v;
    reset = 1'b1; enable = 1'b0; instruction = 16'h0; zero_flag = 1'b0;
    mem_ready = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 32'(act_v), 32'd0);
    reset = 1'b0;
    run_cycle('0);  // START

    do_instr(16'h5200, 0, 1'b0, 1'b0);
    chk("t1_add_alu", 32'(ALU_control), 32'd1);
    do_instr(16'h1200, 3, 1'b0, 1'b0);
    chk("t2_load_mdr", 32'(MDR_control), 32'd1);
    do_instr(16'hD000, 0, 1'b1, 1'b0);
    chk("t3_jpz_taken", 32'(PC_control), 32'd2);
    do_instr(16'hD000, 0, 1'b0, 1'b0);
    chk("t3_jpz_not_taken", 32'(PC_control), 32'd0);
    do_instr(16'h3105, 0, 1'b0, 1'b1);
    chk("t4_copy_dst", 32'(select_destination), 32'd5);
    chk("t4_copy_mdr", 32'(MDR_control), 32'd2);

    for (int i = 0; i < 20; i++) do_instr(tbl_ir[i], tbl_wait[i], 1'b0, 1'b0);

    // Processor disabled: FETCH1 holds with everything low.
    for (int i = 0; i < 10; i++) begin
      noise(); enable = 1'b0; instruction = 16'h5200; run_cycle('0);
    end
    chk("t6_idle_load", 32'(load_instruction), 32'd0);

    // STORE stalled on mem_ready, then aborted by reset.
    noise(); enable = 1'b1; instruction = 16'h2200;
    v = '0; v.ld = 1'b1; run_cycle(v);
    noise(); v = '0; v.pc = 2'd1; run_cycle(v);
    noise(); v = '0; v.mar = 2'd3; run_cycle(v);
    for (int i = 0; i < 2; i++) begin
      noise(); mem_ready = 1'b0; v = '0; v.wr = 1'b1; run_cycle(v);
    end
    chk("t6_store_wait", 32'(write_DRAM), 32'd1);
    #2 reset = 1'b1;
    #1 chk("t6_reset_async", 32'(act_v), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    run_cycle('0);  // START after reset
    do_instr(16'hA100, 0, 1'b0, 1'b0);
    chk("t6_restart_inc", 32'(ALU_control), 32'd7);

    do_instr(16'hF000, 5, 1'b0, 1'b0);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_tx_pulses", 32'(tx_pulses), 32'd1);
    chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
